// File: rtl/seg_scan_mux.sv
// Two-digit time-multiplexed 7-segment scanner: per-frame input snapshot, anti-ghost
// blanking, tens leading-zero suppression and a blinking "--" for out-of-range codes.
module seg_scan_mux #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg_a,
  input  logic [6:0] seg_b,
  output logic [6:0] seg_out,
  output logic [1:0] an_out,
  output logic       frame_tick
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLANK_A = 3'd1,
    SHOW_A  = 3'd2,
    BLANK_B = 3'd3,
    SHOW_B  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [6:0]         shadow_a_q, shadow_a_d;
  logic [6:0]         shadow_b_q, shadow_b_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;
  logic [6:0]         seg_q, seg_d;
  logic [1:0]         an_q, an_d;
  logic               tick_q, tick_d;

  logic in_b, next_b, wrap, snap, frame_done, err_q, err_d;

  // Next-state, snapshot/blink bookkeeping and output decode of the entered state
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    shadow_a_d  = shadow_a_q;
    shadow_b_d  = shadow_b_q;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    seg_d       = SEG_DARK;
    an_d        = 2'b11;
    tick_d      = 1'b0;
    snap        = 1'b0;
    frame_done  = 1'b0;
    next_b      = 1'b0;
    in_b        = (state_q == BLANK_B) || (state_q == SHOW_B);
    wrap        = (div_q == DIV_LAST);
    err_q       = (shadow_a_q == SEG_DARK) && (shadow_b_q == SEG_DARK);

    if (!en) begin
      state_d     = IDLE;
      div_d       = '0;
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = BLANK_A;
      div_d   = '0;
      snap    = 1'b1;
    end else begin
      div_d  = wrap ? '0 : div_q + 1'b1;
      next_b = wrap ? !in_b : in_b;
      if (wrap && in_b) begin
        snap       = 1'b1;
        frame_done = 1'b1;
      end
      if (next_b) state_d = (div_d < BLANK_END) ? BLANK_B : SHOW_B;
      else        state_d = (div_d < BLANK_END) ? BLANK_A : SHOW_A;
      tick_d = next_b && (div_d == DIV_LAST);
    end

    if (snap) begin
      shadow_a_d = seg_a;
      shadow_b_d = seg_b;
    end
    err_d = (shadow_a_d == SEG_DARK) && (shadow_b_d == SEG_DARK);

    // Blink phase advances only across complete error frames
    if (snap && !err_d) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (frame_done && err_q) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = !blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    case (state_d)
      SHOW_A: begin
        if (err_d) begin
          if (!blink_off_d) begin
            an_d  = 2'b10;
            seg_d = SEG_DASH;
          end
        end else begin
          an_d  = 2'b10;
          seg_d = shadow_a_d;
        end
      end
      SHOW_B: begin
        if (err_d) begin
          if (!blink_off_d) begin
            an_d  = 2'b01;
            seg_d = SEG_DASH;
          end
        end else if (!(LZ_SUPPRESS && (shadow_b_d == SEG_ZERO))) begin
          an_d  = 2'b01;
          seg_d = shadow_b_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      shadow_a_q  <= SEG_DARK;
      shadow_b_q  <= SEG_DARK;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      seg_q       <= SEG_DARK;
      an_q        <= 2'b11;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      shadow_a_q  <= shadow_a_d;
      shadow_b_q  <= shadow_b_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with a 16-cycle frame (CLK_DIV=8, BLANK_CYC=2).
module tb_seg_scan_mux;

  localparam int unsigned CLK_DIV      = 8;
  localparam int unsigned BLANK_CYC    = 2;
  localparam int unsigned BLINK_FRAMES = 2;

  localparam logic [6:0] DARK = 7'h7F;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] ONE  = 7'b1111001;
  localparam logic [6:0] TWO  = 7'b0100100;
  localparam logic [6:0] THR  = 7'b0110000;
  localparam logic [6:0] FIVE = 7'b0010010;
  localparam logic [6:0] ZERO = 7'b1000000;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [6:0] seg_a = DARK;
  logic [6:0] seg_b = DARK;
  logic [6:0] seg_out;
  logic [1:0] an_out;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t e;

  seg_scan_mux #(
    .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES), .LZ_SUPPRESS(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seg_a(seg_a), .seg_b(seg_b),
    .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Expected sequence for the first n cycles of one full frame
  task automatic push_frame(input logic [1:0] an_a, input logic [6:0] sa,
                            input logic [1:0] an_b, input logic [6:0] sb_v, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.tick = (i == 2 * CLK_DIV - 1);
      if ((i % CLK_DIV) < BLANK_CYC) begin
        x.an = 2'b11; x.seg = DARK;
      end else if (i < CLK_DIV) begin
        x.an = an_a; x.seg = sa;
      end else begin
        x.an = an_b; x.seg = sb_v;
      end
      sb.push_back(x);
    end
  endtask

  task automatic push_dark(input int n);
    exp_t x;
    x.an = 2'b11; x.seg = DARK; x.tick = 1'b0;
    for (int i = 0; i < n; i++) sb.push_back(x);
  endtask

  // Force IDLE for one edge, then enable with new inputs; the next edge is cycle 1
  task automatic start_frame(input logic [6:0] a, input logic [6:0] b);
    en = 1'b0;
    @(posedge clk); #1;
    seg_a = a; seg_b = b; en = 1'b1;
  endtask

  task automatic test_reset();
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({an_out, seg_out, frame_tick} !== {2'b11, DARK, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got an=%b seg=%b tick=%b want an=11 seg=1111111 tick=0",
                 c, an_out, seg_out, frame_tick);
      end
    end
    rst = 1'b0;
    start_frame(ONE, TWO);
    push_frame(2'b10, ONE, 2'b01, TWO, 4);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL reset_pre cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({an_out, seg_out, frame_tick} !== {2'b11, DARK, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got an=%b seg=%b tick=%b want an=11 seg=1111111 tick=0",
               an_out, seg_out, frame_tick);
    end
    #1 rst = 1'b0;
    push_frame(2'b10, ONE, 2'b01, TWO, 16);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL reset_restart cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
    end
  endtask

  task automatic test_normal();
    start_frame(ONE, TWO);
    push_frame(2'b10, ONE, 2'b01, TWO, 16);
    push_frame(2'b10, ONE, 2'b01, TWO, 16);
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL normal cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
    end
  endtask

  task automatic test_snapshot();
    start_frame(ONE, TWO);
    push_frame(2'b10, ONE, 2'b01, TWO, 16);
    push_frame(2'b10, THR, 2'b01, TWO, 16);
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL snapshot cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
      if (c == 5) seg_a = THR;
    end
  endtask

  task automatic test_lead_zero();
    start_frame(FIVE, ZERO);
    push_frame(2'b10, FIVE, 2'b11, DARK, 16);
    push_frame(2'b10, FIVE, 2'b11, DARK, 16);
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL lead_zero cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
    end
  endtask

  task automatic test_error_blink();
    start_frame(DARK, DARK);
    push_frame(2'b10, DASH, 2'b01, DASH, 16);
    push_frame(2'b10, DASH, 2'b01, DASH, 16);
    push_frame(2'b11, DARK, 2'b11, DARK, 16);
    push_frame(2'b11, DARK, 2'b11, DARK, 16);
    push_frame(2'b10, DASH, 2'b01, DASH, 16);
    push_frame(2'b10, DASH, 2'b01, DASH, 16);
    push_frame(2'b10, ONE, 2'b01, TWO, 16);
    push_frame(2'b10, DASH, 2'b01, DASH, 16);
    push_frame(2'b10, DASH, 2'b01, DASH, 16);
    for (int c = 1; c <= 144; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL error_blink cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
      if (c == 83) begin seg_a = ONE; seg_b = TWO; end
      if (c == 99) begin seg_a = DARK; seg_b = DARK; end
    end
  endtask

  task automatic test_en_drop();
    start_frame(ONE, TWO);
    push_frame(2'b10, ONE, 2'b01, TWO, 12);
    push_dark(6);
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL en_drop cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
      if (c == 12) en = 1'b0;
    end
    seg_a = THR; seg_b = FIVE; en = 1'b1;
    push_frame(2'b10, THR, 2'b01, FIVE, 16);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({an_out, seg_out, frame_tick} !== e) begin
        failures++;
        $display("FAIL en_restart cyc=%0d got an=%b seg=%b tick=%b want an=%b seg=%b tick=%b",
                 c, an_out, seg_out, frame_tick, e.an, e.seg, e.tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_snapshot();
    test_lead_zero();
    test_error_blink();
    test_en_drop();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
